// File: rtl/net_tx_pkg.sv
// Shared types and helpers for the network TX path: arbiter state encoding,
// default stream widths and the round-robin port search.
package net_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int NET_DATA_WIDTH = 512;

    function automatic int keep_width(input int data_width);
        return data_width / 8;
    endfunction

    localparam int NET_KEEP_WIDTH = keep_width(NET_DATA_WIDTH);

    // First requesting port at or above ptr, wrapping modulo n (n <= 8).
    // Scanning from the far end lets the nearest match overwrite later ones.
    function automatic int rr_pick(input logic [7:0] req, input int ptr, input int n);
        int pick;
        int idx;
        pick = ptr;
        for (int i = 7; i >= 0; i--) begin
            if (i < n) begin
                idx = (ptr + i) % n;
                if (req[3'(idx)]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-stream skid buffer: registered outputs, and an upstream ready
// that comes from local registers only, so no combinational path crosses it.
module axis_skid_buffer #(
    parameter int DATA_WIDTH = 512
) (
    input  logic                  net_clk,
    input  logic                  sys_reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);

    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  take_in;
    logic                  load_out;

    // A beat transfers on any edge where valid and ready are both high; valid
    // never waits for ready, and data is held stable while valid is unaccepted.
    assign s_ready  = !skid_valid;
    assign take_in  = s_valid && s_ready;
    assign load_out = m_ready || !m_valid;

    always_ff @(posedge net_clk or posedge sys_reset) begin
        if (sys_reset) begin
            m_valid    <= 1'b0;
            skid_valid <= 1'b0;
        end else if (load_out) begin
            m_valid    <= skid_valid || take_in;
            skid_valid <= 1'b0;
        end else if (take_in) begin
            skid_valid <= 1'b1;
        end
    end

    // Payload registers carry no reset; the valid flags qualify them.
    always_ff @(posedge net_clk) begin
        if (load_out) begin
            m_data <= skid_valid ? skid_data : s_data;
        end else if (take_in) begin
            skid_data <= s_data;
        end
    end

endmodule

// File: rtl/net_tx_arbiter.sv
// Frame-granular round-robin arbiter feeding the shared 512-bit Ethernet TX
// stream; a grant is held for a whole frame and only issued while link_up.
module net_tx_arbiter
    import net_tx_pkg::*;
#(
    parameter int N_PORTS    = 4,
    parameter int DATA_WIDTH = NET_DATA_WIDTH
) (
    input  logic                                  net_clk,
    input  logic                                  sys_reset,
    input  logic                                  link_up,
    input  logic [N_PORTS-1:0]                    s_axis_tvalid,
    output logic [N_PORTS-1:0]                    s_axis_tready,
    input  logic [N_PORTS*DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [N_PORTS*keep_width(DATA_WIDTH)-1:0] s_axis_tkeep,
    input  logic [N_PORTS-1:0]                    s_axis_tlast,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic [DATA_WIDTH-1:0]                 m_axis_tdata,
    output logic [keep_width(DATA_WIDTH)-1:0]     m_axis_tkeep,
    output logic                                  m_axis_tlast,
    output logic [$clog2(N_PORTS)-1:0]            grant_id,
    output logic                                  busy,
    output logic [31:0]                           pkt_count
);

    localparam int KW = keep_width(DATA_WIDTH);
    localparam int GW = $clog2(N_PORTS);
    localparam int PW = DATA_WIDTH + KW + 1;

    arb_state_t        state, state_next;
    logic [GW-1:0]     grant_next;
    logic [GW-1:0]     rr_ptr, ptr_next;
    logic [31:0]       count_next;
    logic [7:0]        req_ext;

    logic [DATA_WIDTH-1:0] port_data [N_PORTS];
    logic [KW-1:0]         port_keep [N_PORTS];

    logic          sel_valid;
    logic          sel_last;
    logic          skid_ready;
    logic          take;
    logic [PW-1:0] skid_out;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        assign port_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign port_keep[i] = s_axis_tkeep[i*KW +: KW];
    end

    assign sel_valid = s_axis_tvalid[grant_id];
    assign sel_last  = s_axis_tlast[grant_id];
    assign take      = (state == BURST) && sel_valid && skid_ready;
    assign busy      = (state == BURST);

    always_comb begin
        req_ext                = '0;
        req_ext[N_PORTS-1:0]   = s_axis_tvalid;
    end

    always_comb begin
        s_axis_tready = '0;
        if (state == BURST) begin
            s_axis_tready[grant_id] = skid_ready;
        end
    end

    // link_up only gates new grants; a frame in flight always runs to tlast.
    always_comb begin
        state_next = state;
        grant_next = grant_id;
        ptr_next   = rr_ptr;
        count_next = pkt_count;
        case (state)
            IDLE: begin
                if (link_up && (|s_axis_tvalid)) begin
                    grant_next = GW'(rr_pick(req_ext, int'(rr_ptr), N_PORTS));
                    state_next = BURST;
                end
            end
            BURST: begin
                if (take && sel_last) begin
                    ptr_next   = GW'((int'(grant_id) + 1) % N_PORTS);
                    count_next = pkt_count + 32'd1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge net_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state     <= IDLE;
            grant_id  <= '0;
            rr_ptr    <= '0;
            pkt_count <= '0;
        end else begin
            state     <= state_next;
            grant_id  <= grant_next;
            rr_ptr    <= ptr_next;
            pkt_count <= count_next;
        end
    end

    axis_skid_buffer #(
        .DATA_WIDTH(PW)
    ) u_skid (
        .net_clk  (net_clk),
        .sys_reset(sys_reset),
        .s_valid  ((state == BURST) && sel_valid),
        .s_ready  (skid_ready),
        .s_data   ({sel_last, port_keep[grant_id], port_data[grant_id]}),
        .m_valid  (m_axis_tvalid),
        .m_ready  (m_axis_tready),
        .m_data   (skid_out)
    );

    assign m_axis_tlast = skid_out[PW-1];
    assign m_axis_tkeep = skid_out[DATA_WIDTH +: KW];
    assign m_axis_tdata = skid_out[DATA_WIDTH-1:0];

endmodule

// File: doc/net_tx_arbiter.md
# net_tx_arbiter

Packet-granular round-robin arbiter that shares the single 512-bit Ethernet TX stream (into frame padding → packet FIFO → CMAC) among up to N_PORTS requesters, e.g. TCP, ARP, ICMP and UDP engines. It locks the grant for a whole frame and never interleaves beats of different frames. It gates new grants on link state and drives a registered, skid-buffered output. It sits directly in front of the network module's `s_axis_net_tx`.

## Interface
Parameters:
- N_PORTS, 4, number of requesters (2..8)
- DATA_WIDTH, 512, tdata width; tkeep is DATA_WIDTH/8

Ports:
- net_clk  in  1  clock for all logic
- sys_reset  in  1  async, active-high reset
- link_up  in  1  high when CMAC TX is usable (network_init_done & rx_aligned), already in net_clk domain
- s_axis_tvalid  in  N_PORTS  per-port valid
- s_axis_tready  out  N_PORTS  per-port ready
- s_axis_tdata  in  N_PORTS*DATA_WIDTH  port i at [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tkeep  in  N_PORTS*DATA_WIDTH/8  per-port keep
- s_axis_tlast  in  N_PORTS  per-port last
- m_axis_tvalid / tready / tdata / tkeep / tlast  out/in/out/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8/1  to padding stage
- grant_id  out  $clog2(N_PORTS)  port currently or last granted
- busy  out  1  high while a frame is locked (state BURST)
- pkt_count  out  32  frames forwarded (tlast beats accepted at input), wraps 2^32-1 → 0

## Operation
- States: IDLE, BURST.
- IDLE:
  - All s_axis_tready are 0.
  - If link_up=1 and any tvalid=1, select the first valid port searching from rr_ptr upward (mod N_PORTS).
  - Register the selection as grant_id and move to BURST next cycle.
  - If link_up=0, stay in IDLE regardless of valid.
- BURST:
  - s_axis_tready[grant_id] = skid-buffer ready; all other readies are 0.
  - Each accepted beat (valid & ready) is pushed unchanged into the skid buffer.
  - On an accepted beat with tlast=1: rr_ptr ← grant_id+1 (mod N_PORTS), pkt_count++, move to IDLE.
- link_up falling during BURST:
  - The current frame completes; frames are never truncated.
  - No new grant is issued until link_up returns.
- A requester dropping tvalid mid-frame stalls the arbiter in BURST. There is no timeout; this is a requester protocol violation.
- Single-beat frames (tlast on first beat) are legal.
- tkeep is passed through unchecked; padding downstream handles short frames.
- Reset (any time, including mid-frame):
  - State → IDLE, rr_ptr 0, grant_id 0, busy 0, pkt_count 0.
  - All s_axis_tready 0; m_axis_tvalid 0; skid buffer emptied.
  - A partially sent frame is discarded.

## Timing
- Grant: a tvalid first seen in IDLE at cycle t gives BURST with tready high at t+1. The first beat is accepted at t+1 and appears on m_axis at t+2.
- Beat latency: input acceptance to m_axis_tvalid is 1 cycle.
- Within a frame with m_axis_tready=1 throughout, throughput is 1 beat/cycle.
- Each frame boundary costs exactly 1 idle input cycle (the BURST→IDLE→BURST turnaround). The output stream shows the same 1-cycle gap.
- m_axis_tready low: the skid buffer holds 2 entries and input tready drops the cycle after the buffer holds ≥1 unsent beat plus a registered one. No beat is lost or duplicated.
- m_axis outputs are registered only (no combinational path from s_* to m_*).
- s_axis_tready depends only on state, grant_id and the skid registers, never combinationally on m_axis_tready.
- busy and grant_id change on the clock edge entering or leaving BURST.

## Structure
- Shared package net_tx_pkg: arb_state_t enum {IDLE, BURST}, DATA_WIDTH default, KEEP_WIDTH derivation.
- Sub-module axis_skid_buffer (2-entry, parameterized DATA_WIDTH), instantiated once on the output. It is also reusable elsewhere on the 512-bit paths.
- Round-robin next-port search is a function in net_tx_pkg.

## Test plan
- Ports 0,1,2 each hold a 3-beat frame at reset release with link_up=1 → output order 0,1,2; each frame contiguous; 1 idle cycle between frames; pkt_count=3.
- Port 3 streams continuous 1-beat frames while port 1 requests once → port 1's frame is granted within one rotation (after at most one port-3 frame); pkt_count increments per frame.
- link_up=0 with port 0 valid for 10 cycles → s_axis_tready stays 0 and m_axis_tvalid stays 0. link_up→1 → grant at next cycle, first beat out 2 cycles later.
- m_axis_tready toggles randomly (50%) during an 8-beat frame with data = beat index → output data sequence 0..7 exact, tlast only on beat 7.
- link_up drops at beat 2 of a 5-beat frame → beats 3–5 still forwarded; no further grant while link_up=0.
- sys_reset asserted mid-frame at beat 4 → next cycle all outputs at reset values, pkt_count=0. After release, the next grant goes to the lowest valid port from port 0.
